// File: rtl/load_store_unit.sv
// Load/store initiator between the CPU datapath and a word-organised, single-port
// DataMemory with one-cycle registered reads. Define LSU_BIG_ENDIAN_EN for big-endian lanes.
module load_store_unit #(
    parameter int data_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [31:0]           addr,
    input  logic [data_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [data_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [data_WIDTH-1:0] mem_dataIn,
    output logic                  mem_we,
    input  logic [data_WIDTH-1:0] mem_dataOut
);

`ifdef LSU_BIG_ENDIAN_EN
    localparam bit BIG_ENDIAN = 1'b1;
`else
    localparam bit BIG_ENDIAN = 1'b0;
`endif

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WAIT,
        S_LD_CAP,
        S_RMW_WAIT,
        S_RMW_CAP,
        S_ST_WR
    } state_e;

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [data_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
    logic [data_WIDTH-1:0]   mdin_q, mdin_d;
    logic                    mwe_q, mwe_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [data_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    misaligned;

    // Bits above the DataMemory window are remapped by the memory itself.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    // Bit position of the addressed lane inside the 32-bit word.
    function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] sz);
        logic [4:0] sh;
        sh = 5'd0;
        if (sz == SZ_BYTE) begin
            sh = {(BIG_ENDIAN ? ~off : off), 3'b000};
        end else if (sz == SZ_HALF) begin
            sh = {(BIG_ENDIAN ? ~off[1] : off[1]), 4'b0000};
        end
        return sh;
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> lane_shift(off, sz);
        case (sz)
            SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] mask;
        logic [4:0]  sh;
        sh   = lane_shift(off, sz);
        mask = ((sz == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        return (word & ~mask) | ((data << sh) & mask);
    endfunction

    assign misaligned = (size == 2'b11)
                      | ((size == SZ_HALF) & addr[0])
                      | ((size == SZ_WORD) & (addr[1:0] != 2'b00));

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mwe_d   = 1'b0;
        rdata_d = rdata_q;
        maddr_d = maddr_q;
        mdin_d  = mdin_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    maddr_d = addr[ADDR_WIDTH+1:2];
                    off_d   = addr[1:0];
                    size_d  = size;
                    uns_d   = unsigned_ld;
                    wdata_d = wdata;
                    if (misaligned) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (!wr) begin
                        state_d = S_LD_WAIT;
                    end else if (size == SZ_WORD) begin
                        mdin_d  = wdata;
                        mwe_d   = 1'b1;
                        state_d = S_ST_WR;
                    end else begin
                        state_d = S_RMW_WAIT;
                    end
                end
            end
            S_LD_WAIT:  state_d = S_LD_CAP;
            S_LD_CAP: begin
                rdata_d = extract_lane(mem_dataOut, off_q, size_q, uns_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_RMW_WAIT: state_d = S_RMW_CAP;
            S_RMW_CAP: begin
                mdin_d  = merge_lane(mem_dataOut, wdata_q, off_q, size_q);
                mwe_d   = 1'b1;
                state_d = S_ST_WR;
            end
            S_ST_WR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            maddr_q <= '0;
            mdin_q  <= '0;
            mwe_q   <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
            mdin_q  <= mdin_d;
            mwe_q   <= mwe_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign mem_address = maddr_q;
    assign mem_dataIn  = mdin_q;
    assign mem_we      = mwe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// compared against a byte-addressed memory model and an access-latency model.
module tb_load_store_unit;
    localparam int AW = 10;
    localparam int DW = 32;

`ifdef LSU_BIG_ENDIAN_EN
    localparam bit BIG = 1'b1;
`else
    localparam bit BIG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          wr = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          unsigned_ld = 1'b0;
    logic [31:0]   addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          busy, done, err, mem_we;
    logic [DW-1:0] rdata, mem_dataIn, mem_dataOut;
    logic [AW-1:0] mem_address;

    always #5 clk = ~clk;

    load_store_unit #(.data_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_we(mem_we),
        .mem_dataOut(mem_dataOut)
    );

    // DataMemory: word-organised, registered read, plus a bench preset port.
    logic [31:0]   dmem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) dmem[pre_addr] <= pre_data;
        else if (mem_we) dmem[mem_address] <= mem_dataIn;
        mem_dataOut <= dmem[mem_address];
    end

    // Reference: memory as bytes, plus the last load result.
    logic [7:0]  ref_mem [0:(4<<AW)-1];
    logic [31:0] ref_rdata = '0;
    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    int          done_exp = 0;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [11:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (BIG) v = {v[23:0], ref_mem[int'(a) + i]};
            else     v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        end
        return v;
    endfunction

    task automatic ref_write(input logic [11:0] a, input int n, input logic [31:0] d);
        logic [31:0] b;
        for (int i = 0; i < n; i++) begin
            b = BIG ? (d >> (8 * (n - 1 - i))) : (d >> (8 * i));
            ref_mem[int'(a) + i] = b[7:0];
        end
    endtask

    task automatic preset_word(input int widx, input logic [31:0] v);
        logic [AW-1:0] wa;
        wa = AW'(widx);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = wa; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
        ref_write(12'(widx * 4), 4, v);
    endtask

    // One access: drive, wait for done, compare against the reference model.
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input logic hold,
                          input string tag);
        logic [11:0] ba;
        logic        mis;
        int          n, exp_lat, lat, we_cnt;
        logic [31:0] we_data, exp_word, ld, msk;
        bit          got_done;
        ba  = a[11:0];
        n   = 1 << sz;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        exp_lat  = mis ? 0 : (!w ? 2 : (sz == 2'd2 ? 1 : 3));
        exp_word = '0;
        if (!mis && !w) begin
            ld = ref_read(ba, n);
            if (n < 4) begin
                msk = (32'h1 << (8 * n)) - 32'h1;
                if (!u && ld[8 * n - 1]) ld = ld | ~msk;
            end
            ref_rdata = ld;
        end
        if (!mis && w) begin
            ref_write(ba, n, d);
            exp_word = ref_read({ba[11:2], 2'b00}, 4);
        end
        done_exp++;

        @(negedge clk);
        wr = w; size = sz; unsigned_ld = u; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        check({tag, "_maddr"}, 32'(mem_address), 32'(ba[11:2]));
        check({tag, "_busy"}, 32'(busy), 32'(!mis));

        lat = 0; we_cnt = 0; we_data = '0; got_done = 0;
        while (1) begin
            if (mem_we) begin
                we_cnt++;
                we_data = mem_dataIn;
            end
            if (done) begin
                got_done = 1;
                break;
            end
            if (lat >= 8) break;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!got_done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            check({tag, "_err"}, 32'(err), 32'(mis));
            check({tag, "_busy_done"}, 32'(busy), 32'd0);
        end
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'((w && !mis) ? 1 : 0));
        if (w && !mis) check({tag, "_we_data"}, we_data, exp_word);
        check({tag, "_rdata"}, rdata, ref_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] lane0, sb_addr, r;
        logic [1:0]  rsz;
        lane0   = BIG ? 32'h3 : 32'h0;
        sb_addr = BIG ? 32'h5 : 32'h6;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_maddr", 32'(mem_address), 32'd0);
        check("rst_mdin", mem_dataIn, 32'd0);
        check("rst_mwe", 32'(mem_we), 32'd0);

        for (int i = 0; i < 16; i++) preset_word(i, 32'h0);
        preset_word(0, 32'h0000_07D1);
        preset_word(1, 32'h0000_0FA1);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, "ldw0");
        check("plan_ldw0", rdata, 32'h0000_07D1);
        access(1'b0, 2'd0, 1'b0, lane0, 32'h0, 1'b0, "ldb_s");
        check("plan_ldb_s", rdata, 32'hFFFF_FFD1);
        access(1'b0, 2'd0, 1'b1, lane0, 32'h0, 1'b0, "ldb_u");
        check("plan_ldb_u", rdata, 32'h0000_00D1);
        access(1'b1, 2'd0, 1'b0, sb_addr, 32'hFFFF_FFAA, 1'b0, "stb");
        check("plan_stb_mem", dmem[1], 32'h00AA_0FA1);
        access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0, "ldw1");
        check("plan_ldw1", rdata, 32'h00AA_0FA1);
        access(1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 1'b0, "ldh_mis");
        check("plan_mis_rdata", rdata, 32'h00AA_0FA1);
        access(1'b1, 2'd2, 1'b0, 32'h8, 32'h1234_5678, 1'b0, "stw8");
        access(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 1'b0, "rsvd");
        access(1'b0, 2'd2, 1'b0, 32'hA, 32'h0, 1'b0, "ldw_mis");
        access(1'b1, 2'd1, 1'b0, 32'h3, 32'hBEEF, 1'b0, "sth_mis");
        access(1'b1, 2'd1, 1'b0, 32'hA, 32'h5555_BEEF, 1'b0, "sth");
        access(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 1'b0, "ldh_s");
        access(1'b0, 2'd1, 1'b1, 32'h8, 32'h0, 1'b0, "ldh_u");

        // Back-to-back with req held through busy and done cycles.
        access(1'b1, 2'd2, 1'b0, 32'hC, 32'hCAFE_F00D, 1'b1, "b2b_stw");
        access(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 1'b1, "b2b_ldw");
        check("plan_b2b", rdata, 32'hCAFE_F00D);
        access(1'b1, 2'd0, 1'b0, 32'hD, 32'h0000_0077, 1'b1, "b2b_stb");
        access(1'b0, 2'd1, 1'b0, 32'hE, 32'h0, 1'b1, "b2b_ldh");
        req = 1'b0;

        // Reset asserted while the RMW read is being captured.
        preset_word(5, 32'h1122_3344);
        @(negedge clk);
        wr = 1'b1; size = 2'd0; unsigned_ld = 1'b0; addr = 32'h15; wdata = 32'h55; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", 32'(mem_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_we2", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_rdata = '0;
        check("rst_mid_rdata", rdata, 32'd0);
        access(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, "rst_reload");
        check("plan_rst_mem", rdata, 32'h1122_3344);

        for (int k = 0; k < 300; k++) begin
            r   = $urandom;
            rsz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            access(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
                   {r[31:12], 6'd0, 6'($urandom_range(0, 63))}, $urandom,
                   1'($urandom_range(0, 3) == 0), "rnd");
        end
        req = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_total", 32'(done_seen), 32'(done_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator between the MIPS CPU datapath and the word-organised, single-port DataMemory. Accepts byte/halfword/word load and store requests on byte addresses, drives DataMemory's word address, write data and write enable, and absorbs its one-cycle synchronous read latency. Sub-word stores use a read-modify-write sequence; sub-word loads are lane-extracted and sign- or zero-extended. Misaligned accesses are rejected with an error flag and no memory access.

## Interface
- data_WIDTH, 32, data word width; must be 32.
- ADDR_WIDTH, 10, DataMemory word-address width.

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe, sampled only in IDLE
- wr  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- unsigned_ld  in  1  1 = zero-extend sub-word load, 0 = sign-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified for byte/halfword
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  misaligned/reserved-size flag, valid with done
- rdata  out  32  load result, held until next load completes
- mem_address  out  ADDR_WIDTH  word address to DataMemory = addr[ADDR_WIDTH+1:2]
- mem_dataIn  out  32  write data to DataMemory
- mem_we  out  1  DataMemory write enable
- mem_dataOut  in  32  DataMemory registered read data

## Operation
- All outputs registered. Reset values: busy 0, done 0, err 0, rdata 0, mem_address 0, mem_dataIn 0, mem_we 0; state IDLE.
- States: IDLE, LD_WAIT, LD_CAP, RMW_WAIT, RMW_CAP, ST_WR.
- IDLE, req=1 (accept edge): latch addr offset, size, wr, unsigned_ld, wdata; drive mem_address. Then:
  - Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0, size=11): done=1, err=1, stay IDLE, mem_we stays 0, rdata unchanged.
  - Load: mem_we=0 -> LD_WAIT.
  - Word store: mem_dataIn=wdata, mem_we=1 -> ST_WR.
  - Byte/halfword store: mem_we=0 -> RMW_WAIT.
- LD_WAIT -> LD_CAP (DataMemory registers the word this edge).
- LD_CAP: capture mem_dataOut, extract lane, extend, write rdata; done=1, err=0 -> IDLE.
- RMW_WAIT -> RMW_CAP.
- RMW_CAP: merge wdata[7:0] or wdata[15:0] into addressed lane of mem_dataOut, other lanes untouched; mem_dataIn=merged, mem_we=1 -> ST_WR.
- ST_WR: mem_we=0, done=1, err=0 -> IDLE.
- done is 0 in every cycle except the completion cycle; req while busy is ignored, not queued.
- req may be asserted in the done cycle (busy=0) and is accepted.
- mem_we is high for exactly one cycle per store, never for loads or rejected accesses.
- addr bits above ADDR_WIDTH+1 are ignored (DataMemory applies its own region remap).

## Timing
- Latency, accept edge to edge raising done: misaligned 0, word store 1, load 2, sub-word store 3.
- Throughput: one access per latency+1 cycles (back-to-back req in done cycle).
- Reset asserted mid-operation: state IDLE and mem_we 0 immediately (asynchronous); no done pulse; pending store may or may not have committed only if mem_we was already high at the preceding edge.

## Configuration
- LSU_BIG_ENDIAN_EN defined: byte offset 0 = bits [31:24], offset 3 = [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
- Undefined: little-endian; byte offset 0 = [7:0], halfword offset 0 = [15:0].
- Applies identically to load extraction and RMW merge; nothing else changes.

## Test plan
- Word 0 preset to 0x000007D1; load word addr 0x0 -> done 2 edges after accept, rdata=0x000007D1, err=0, mem_we never high.
- Big-endian: load byte addr 0x3 signed -> rdata=0xFFFFFFD1; unsigned -> 0x000000D1; little-endian build addr 0x0 gives same values.
- Word 1 preset 0x00000FA1; big-endian store byte 0xAA to addr 0x5 -> one mem_we pulse with mem_dataIn=0x00AA0FA1, done 3 edges after accept; reload word -> 0x00AA0FA1.
- Load halfword addr 0x1 -> done and err high at accept edge, mem_we 0, rdata unchanged; next word store addr 0x8 wdata 0x12345678 -> err=0, done after 1 edge.
- Back-to-back: store word then load same address, req held in done cycle -> load returns the stored value, no lost or duplicated done.
- rst_n low during RMW_CAP -> mem_we 0, busy 0, no done; memory word unchanged; next request completes normally.
